// File: rtl/phys_reg_free_list_pkg.sv
// Shared types for the rename-stage physical register free list.
// Default machine sizing lives here so the list and its users agree on tag width.
package qu_common;

    localparam int DEF_LOG_RF_DEPTH = 8;
    localparam int DEF_PHY_RF_DEPTH = 16;
    localparam int DEF_TAG_W        = $clog2(DEF_PHY_RF_DEPTH);

    typedef logic [DEF_TAG_W-1:0] phys_tag_t;

    typedef enum logic {
        FL_INIT,
        FL_READY
    } free_list_state_t;

endpackage

// File: rtl/phys_reg_free_list_ram.sv
// Free-list tag storage: one synchronous write port, one asynchronous read port.
module free_list_ram #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list with a speculative head for rename and a committed
// head for retire, so a squash restores every speculatively allocated tag at once.
module phys_reg_free_list
    import qu_common::*;
#(
    parameter int LOG_RF_DEPTH = DEF_LOG_RF_DEPTH,
    parameter int PHY_RF_DEPTH = DEF_PHY_RF_DEPTH,
    localparam int FREE_DEPTH  = PHY_RF_DEPTH - LOG_RF_DEPTH,
    localparam int TAG_W       = $clog2(PHY_RF_DEPTH),
    localparam int CNT_W       = $clog2(FREE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             empty,
    output logic [CNT_W-1:0] free_count,
    input  logic             release_en,
    input  logic [TAG_W-1:0] release_tag,
    input  logic             commit_en,
    input  logic             rollback,
    output logic             ready,
    output logic             err
);

    localparam int IDX_W = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;

    // Pointers are an index plus a wrap bit, so equal indices distinguish full from empty.
    typedef logic [IDX_W:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p[IDX_W-1:0] == IDX_W'(FREE_DEPTH - 1)) begin
            return {~p[IDX_W], {IDX_W{1'b0}}};
        end
        return p + ptr_t'(1);
    endfunction

    function automatic logic [CNT_W-1:0] ptr_diff(input ptr_t a, input ptr_t b);
        int d;
        d = int'(a[IDX_W-1:0]) - int'(b[IDX_W-1:0]);
        if (a[IDX_W] != b[IDX_W]) begin
            d = d + FREE_DEPTH;
        end
        return CNT_W'(d);
    endfunction

    free_list_state_t state;
    logic [IDX_W-1:0] init_cnt;
    ptr_t             spec_head;
    ptr_t             commit_head;
    ptr_t             tail;

    logic             overflow;
    logic             release_ok;
    logic             commit_bad;
    logic             commit_ok;
    ptr_t             commit_next;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [TAG_W-1:0] wr_data;
    logic [TAG_W-1:0] rd_tag;

    assign ready      = (state == FL_READY);
    assign empty      = !ready || (tail == spec_head);
    assign alloc_gnt  = ready && alloc_req && !empty && !rollback;
    assign alloc_tag  = ready ? rd_tag : '0;
    assign free_count = ptr_diff(tail, spec_head);

    assign overflow    = (ptr_diff(tail, commit_head) == CNT_W'(FREE_DEPTH));
    assign release_ok  = ready && release_en && !overflow;
    assign commit_bad  = (commit_head == spec_head);
    assign commit_ok   = ready && commit_en && !commit_bad;
    assign commit_next = commit_ok ? ptr_inc(commit_head) : commit_head;

    // Initialisation and commit releases share the single write port, split by state.
    assign wr_en   = !ready || release_ok;
    assign wr_addr = ready ? tail[IDX_W-1:0] : init_cnt;
    assign wr_data = ready ? release_tag : (TAG_W'(LOG_RF_DEPTH) + TAG_W'(init_cnt));

    free_list_ram #(
        .DEPTH  (FREE_DEPTH),
        .WIDTH  (TAG_W),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (spec_head[IDX_W-1:0]),
        .rd_data (rd_tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FL_INIT;
            init_cnt    <= '0;
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                FL_INIT: begin
                    if (init_cnt == IDX_W'(FREE_DEPTH - 1)) begin
                        state <= FL_READY;
                        tail  <= {1'b1, {IDX_W{1'b0}}};
                    end else begin
                        init_cnt <= init_cnt + IDX_W'(1);
                    end
                end
                FL_READY: begin
                    if (release_ok) begin
                        tail <= ptr_inc(tail);
                    end
                    commit_head <= commit_next;
                    // A squash wins over a grant; it already blocks alloc_gnt combinationally.
                    if (rollback) begin
                        spec_head <= commit_next;
                    end else if (alloc_gnt) begin
                        spec_head <= ptr_inc(spec_head);
                    end
                    if ((release_en && overflow) || (commit_en && commit_bad)) begin
                        err <= 1'b1;
                    end
                end
                default: state <= FL_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for the physical register free list (8 architectural, 16 physical).
module tb_phys_reg_free_list;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [3:0] alloc_tag;
    logic       empty;
    logic [3:0] free_count;
    logic       release_en;
    logic [3:0] release_tag;
    logic       commit_en;
    logic       rollback;
    logic       ready;
    logic       err;

    int vectors;
    int miscompares;

    phys_reg_free_list #(
        .LOG_RF_DEPTH (8),
        .PHY_RF_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_tag   (alloc_tag),
        .empty       (empty),
        .free_count  (free_count),
        .release_en  (release_en),
        .release_tag (release_tag),
        .commit_en   (commit_en),
        .rollback    (rollback),
        .ready       (ready),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs settle before the next rise.
    task automatic applyStimulus(input logic req, input logic rel, input logic [3:0] rtag,
                                 input logic com, input logic rb);
        @(negedge clk);
        alloc_req   = req;
        release_en  = rel;
        release_tag = rtag;
        commit_en   = com;
        rollback    = rb;
        #1;
    endtask

    task automatic resetAndInit();
        @(negedge clk);
        rst = 1'b1;
        alloc_req = 1'b0; release_en = 1'b0; release_tag = '0; commit_en = 1'b0; rollback = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_tags[8];
        exp_tags = '{10, 11, 12, 13, 14, 15, 5, 6};
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        alloc_req = 1'b0; release_en = 1'b0; release_tag = '0; commit_en = 1'b0; rollback = 1'b0;

        // Reset state, then ready exactly 8 posedges after release
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_count", free_count, 0);
        checkOutput("rst_tag", alloc_tag, 0);
        checkOutput("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        alloc_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 7) begin
                checkOutput("init_ready_early", ready, 0);
                checkOutput("init_gnt_blocked", alloc_gnt, 0);
            end
        end
        checkOutput("init_ready", ready, 1);
        checkOutput("init_count", free_count, 8);
        checkOutput("init_tag", alloc_tag, 8);
        checkOutput("init_empty", empty, 0);

        // Drain the list: tags 8..15, then empty
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 0, 0, 0, 0);
            if (k < 8) begin
                checkOutput($sformatf("drain_gnt%0d", k), alloc_gnt, 1);
                checkOutput($sformatf("drain_tag%0d", k), alloc_tag, 8 + k);
            end
        end
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_gnt_off", alloc_gnt, 0);
        checkOutput("drain_count", free_count, 0);

        // Retire one so the release fits, then release into an empty list: no bypass
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 1, 3, 0, 0);
        checkOutput("nobypass_gnt", alloc_gnt, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("released_gnt", alloc_gnt, 1);
        checkOutput("released_tag", alloc_tag, 3);
        checkOutput("released_count", free_count, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("released_empty", empty, 1);

        // Rollback to the committed head
        resetAndInit();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("spec_tag%0d", k), alloc_tag, 8 + k);
        end
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("rb_gnt_blocked", alloc_gnt, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rb_tag", alloc_tag, 9);
        checkOutput("rb_count", free_count, 7);
        checkOutput("rb_err", err, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rb_realloc_tag", alloc_tag, 9);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rbc_tag", alloc_tag, 10);
        checkOutput("rbc_count", free_count, 6);
        checkOutput("rbc_err", err, 0);

        // Commit underflow, then fill to capacity and overflow
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 5, 0, 0);
        checkOutput("underflow_err", err, 1);
        applyStimulus(0, 1, 6, 0, 0);
        applyStimulus(0, 1, 7, 0, 0);
        checkOutput("full_count", free_count, 8);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("overflow_count", free_count, 8);
        checkOutput("overflow_tag", alloc_tag, 10);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("full_tag%0d", k), alloc_tag, exp_tags[k]);
        end
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("full_drained_gnt", alloc_gnt, 0);
        checkOutput("err_sticky", err, 1);

        // Rollback exposes the committed head, then async reset mid-allocation
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("commit_held_count", free_count, 8);
        checkOutput("commit_held_tag", alloc_tag, 10);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("mid_tag0", alloc_tag, 10);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("mid_tag1", alloc_tag, 11);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_ready", ready, 0);
        checkOutput("async_gnt", alloc_gnt, 0);
        checkOutput("async_empty", empty, 1);
        checkOutput("async_count", free_count, 0);
        checkOutput("async_tag", alloc_tag, 0);
        checkOutput("async_err", err, 0);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("reinit_ready", ready, 1);
        checkOutput("reinit_count", free_count, 8);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reinit_gnt", alloc_gnt, 1);
        checkOutput("reinit_tag", alloc_tag, 8);

        applyStimulus(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
